// File: rtl/img_sram_pkg.sv
// Shared types and Gaussian coefficient generation for the image SRAM line engines.
package img_sram_pkg;

  typedef enum logic [1:0] {
    PadMirror  = 2'd0,
    PadClamp   = 2'd1,
    PadZero    = 2'd2,
    PadIllegal = 2'd3
  } pad_mode_e;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StFin} state_e;

  // Bell-shaped integer weight; larger sigma widens the kernel.
  function automatic int unsigned gauss_w(input int unsigned sigma, input int unsigned tap,
                                          input int unsigned r);
    int unsigned d;
    d = (tap > r) ? tap - r : r - tap;
    return (32'd1024 * (sigma + 1)) / (sigma + 1 + d * d);
  endfunction

  // Q0.16 coefficient; the centre tap absorbs rounding so each set sums to exactly 65536.
  function automatic logic [15:0] gauss_coef(input int unsigned sigma, input int unsigned tap,
                                             input int unsigned r);
    longint unsigned sum, acc;
    sum = 0;
    acc = 0;
    for (int unsigned i = 0; i <= 2 * r; i++) sum += 64'(gauss_w(sigma, i, r));
    if (tap != r) return 16'(64'(gauss_w(sigma, tap, r)) * 64'd65536 / sum);
    for (int unsigned i = 0; i <= 2 * r; i++) begin
      if (i != r) acc += 64'(gauss_w(sigma, i, r)) * 64'd65536 / sum;
    end
    return 16'(64'd65536 - acc);
  endfunction

endpackage

// File: rtl/gauss_kernel_dotprod_p.sv
// Combinational Gaussian window dot product with half-up rounding and saturation.
module gauss_kernel_dotprod_p
  import img_sram_pkg::*;
#(
  parameter int R       = 5,
  parameter int PIX_W   = 8,
  parameter int SIGMA_W = 3
) (
  input  logic [SIGMA_W-1:0]        sigma,
  input  logic [2*R:0][PIX_W-1:0]   window,
  output logic [PIX_W-1:0]          pix
);

  localparam int Taps   = 2 * R + 1;
  localparam int NSig   = 1 << SIGMA_W;
  localparam int AccW   = PIX_W + 16 + $clog2(Taps);
  localparam int QW     = AccW - 16;
  localparam int PixMax = (1 << PIX_W) - 1;

  logic [15:0]     coef [NSig][Taps];
  logic [AccW-1:0] acc, rnd;
  logic [QW-1:0]   q;

  for (genvar s = 0; s < NSig; s++) begin : g_sig
    for (genvar t = 0; t < Taps; t++) begin : g_tap
      localparam logic [15:0] C = gauss_coef(s, t, R);
      assign coef[s][t] = C;
    end
  end

  always_comb begin
    acc = '0;
    for (int t = 0; t < Taps; t++) begin
      acc = acc + AccW'(coef[sigma][t]) * AccW'(window[t]);
    end
    rnd = acc + AccW'(32768);
    q   = QW'(rnd >> 16);
    pix = (q > QW'(PixMax)) ? '1 : q[PIX_W-1:0];
  end

endmodule

// File: rtl/conv_line_engine.sv
// Row-wise Gaussian convolution engine: streams the image SRAM with border padding and
// writes convolved pixels (optionally transposed) to the buffer SRAM.
module conv_line_engine
  import img_sram_pkg::*;
#(
  parameter int PIX_W   = 8,
  parameter int DIM_W   = 8,
  parameter int R       = 5,
  parameter int SIGMA_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DIM_W-1:0]   nrows,
  input  logic [DIM_W-1:0]   ncols,
  input  logic [SIGMA_W-1:0] sigma,
  input  logic               transpose,
  input  logic [1:0]         pad_mode,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               img_rd_en,
  output logic [DIM_W-1:0]   img_row,
  output logic [DIM_W-1:0]   img_col,
  input  logic [PIX_W-1:0]   img_dout,
  output logic               buf_we,
  output logic [DIM_W-1:0]   buf_row,
  output logic [DIM_W-1:0]   buf_col,
  output logic [PIX_W-1:0]   buf_din
);

  localparam int Taps = 2 * R + 1;
  localparam int VW   = DIM_W + 2;
  localparam int CntW = $clog2(Taps + 1);

  typedef logic signed [VW-1:0] vidx_t;

  state_e                      state_q;
  pad_mode_e                   pad_q, mode, pm_in;
  logic [DIM_W-1:0]            nrows_q, ncols_q, row_q, nxt_row, s1_row;
  logic [SIGMA_W-1:0]          sigma_q;
  logic                        transpose_q, rd_act_q, zero_q, drain_q;
  logic                        idle, bad, issue, last_rd, nxt_zero;
  logic                        s1_valid, s1_zero, s1_first;
  vidx_t                       v_q, cols, last_v, nxt_v, pc, s1_col;
  logic [Taps-1:0][PIX_W-1:0]  window_q;
  logic [CntW-1:0]             cnt_q, cnt_nxt;

  // Next virtual read index and its physical column after border padding.
  always_comb begin
    idle    = (state_q == StIdle);
    pm_in   = pad_mode_e'(pad_mode);
    mode    = idle ? pm_in : pad_q;
    cols    = vidx_t'(idle ? ncols : ncols_q);
    last_v  = vidx_t'(ncols_q) + vidx_t'(R - 1);
    last_rd = (v_q == last_v) && (row_q == nrows_q - DIM_W'(1));
    bad     = (nrows == '0) || (ncols == '0) || (pm_in == PadIllegal) ||
              ((pm_in == PadMirror) && (int'(ncols) <= R));
    issue   = (idle && start && !bad) || ((state_q == StRun) && !last_rd);
    if (idle || (v_q == last_v)) begin
      nxt_v   = vidx_t'(-R);
      nxt_row = idle ? '0 : row_q + DIM_W'(1);
    end else begin
      nxt_v   = v_q + vidx_t'(1);
      nxt_row = row_q;
    end
    nxt_zero = 1'b0;
    pc       = nxt_v;
    if (nxt_v < 0) begin
      case (mode)
        PadMirror: pc = -nxt_v;
        PadClamp:  pc = '0;
        default: begin
          pc       = '0;
          nxt_zero = 1'b1;
        end
      endcase
    end else if (nxt_v >= cols) begin
      case (mode)
        PadMirror: pc = (cols <<< 1) - vidx_t'(2) - nxt_v;
        PadClamp:  pc = cols - vidx_t'(1);
        default: begin
          pc       = '0;
          nxt_zero = 1'b1;
        end
      endcase
    end
    cnt_nxt = s1_first ? CntW'(1) : ((cnt_q == CntW'(Taps)) ? cnt_q : cnt_q + CntW'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      nrows_q     <= '0;
      ncols_q     <= '0;
      sigma_q     <= '0;
      transpose_q <= 1'b0;
      pad_q       <= PadMirror;
      drain_q     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      err  <= 1'b0;
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start && bad) begin
            err <= 1'b1;
          end else if (start) begin
            nrows_q     <= nrows;
            ncols_q     <= ncols;
            sigma_q     <= sigma;
            transpose_q <= transpose;
            pad_q       <= pm_in;
            busy        <= 1'b1;
            state_q     <= StRun;
          end
        end
        StRun: begin
          if (last_rd) begin
            drain_q <= 1'b0;
            state_q <= StDrain;
          end
        end
        StDrain: begin
          drain_q <= 1'b1;
          if (drain_q) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StFin;
          end
        end
        StFin:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_act_q  <= 1'b0;
      zero_q    <= 1'b0;
      v_q       <= '0;
      row_q     <= '0;
      img_rd_en <= 1'b0;
      img_row   <= '0;
      img_col   <= '0;
    end else if (issue) begin
      rd_act_q  <= 1'b1;
      zero_q    <= nxt_zero;
      v_q       <= nxt_v;
      row_q     <= nxt_row;
      img_rd_en <= !nxt_zero;
      img_row   <= nxt_row;
      img_col   <= DIM_W'(pc);
    end else begin
      rd_act_q  <= 1'b0;
      zero_q    <= 1'b0;
      img_rd_en <= 1'b0;
    end
  end

  // Data returns one cycle after the read; the shift happens at the end of that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_zero  <= 1'b0;
      s1_first <= 1'b0;
      s1_row   <= '0;
      s1_col   <= '0;
      window_q <= '0;
      cnt_q    <= '0;
      buf_we   <= 1'b0;
      buf_row  <= '0;
      buf_col  <= '0;
    end else begin
      s1_valid <= rd_act_q;
      s1_zero  <= zero_q;
      s1_first <= (v_q == vidx_t'(-R));
      s1_row   <= row_q;
      s1_col   <= v_q - vidx_t'(R);
      buf_we   <= 1'b0;
      if (s1_valid) begin
        for (int i = Taps - 1; i > 0; i--) window_q[i] <= window_q[i-1];
        window_q[0] <= s1_zero ? '0 : img_dout;
        cnt_q       <= cnt_nxt;
        buf_we      <= (cnt_nxt == CntW'(Taps));
        buf_row     <= transpose_q ? DIM_W'(s1_col) : s1_row;
        buf_col     <= transpose_q ? s1_row : DIM_W'(s1_col);
      end
    end
  end

  gauss_kernel_dotprod_p #(
    .R       (R),
    .PIX_W   (PIX_W),
    .SIGMA_W (SIGMA_W)
  ) u_dotprod (
    .sigma  (sigma_q),
    .window (window_q),
    .pix    (buf_din)
  );

endmodule

// File: tb/tb_conv_line_engine.sv
// Self-checking bench: per-cycle comparison against a frame-level model of reads and writes.
module tb_conv_line_engine;
  import img_sram_pkg::*;

  localparam int TR = 2;
  localparam int PW = 8;
  localparam int DW = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst, start, transpose;
  logic [DW-1:0] nrows, ncols;
  logic [SW-1:0] sigma;
  logic [1:0]    pad_mode;
  logic          busy, done, err, img_rd_en, buf_we;
  logic [DW-1:0] img_row, img_col, buf_row, buf_col;
  logic [PW-1:0] img_dout, buf_din;

  conv_line_engine #(
    .PIX_W   (PW),
    .DIM_W   (DW),
    .R       (TR),
    .SIGMA_W (SW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .nrows     (nrows),
    .ncols     (ncols),
    .sigma     (sigma),
    .transpose (transpose),
    .pad_mode  (pad_mode),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .img_rd_en (img_rd_en),
    .img_row   (img_row),
    .img_col   (img_col),
    .img_dout  (img_dout),
    .buf_we    (buf_we),
    .buf_row   (buf_row),
    .buf_col   (buf_col),
    .buf_din   (buf_din)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [16][16];
  // Garbage on unread cycles so a missing zero-inject is visible.
  always @(posedge clk) img_dout <= img_rd_en ? mem[img_row[3:0]][img_col[3:0]] : 8'($urandom);

  int n_vec = 0;
  int n_err = 0;
  int res [16][16];
  int col_seq [32];
  int done_cyc;
  int wr_cnt;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int pcol(input int v, input int nc, input int pm);
    if (v < 0) return (pm == 0) ? -v : ((pm == 1) ? 0 : -1);
    if (v >= nc) return (pm == 0) ? 2 * (nc - 1) - v : ((pm == 1) ? nc - 1 : -1);
    return v;
  endfunction

  function automatic int model_pix(input int r, input int c, input int nc, input int pm,
                                   input int sg);
    longint acc;
    int     p, q;
    acc = 0;
    for (int t = 0; t <= 2 * TR; t++) begin
      p = pcol(c - TR + t, nc, pm);
      if (p >= 0) acc += longint'(gauss_coef(sg, t, TR)) * longint'(mem[r][p]);
    end
    q = int'((acc + 32768) >>> 16);
    return (q > 255) ? 255 : q;
  endfunction

  task automatic fill(input int mode, input int val);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) mem[r][c] = (mode == 0) ? 8'(val) : 8'($urandom);
  endtask

  task automatic run_frame(input int nr, input int nc, input int sg, input int tp,
                           input int pm, input bit poke);
    int w, n, row, c, m, p, er, ec;
    w = nc + 2 * TR;
    n = nr * w;
    wr_cnt = 0;
    done_cyc = -1;
    @(negedge clk);
    start = 1'b1; nrows = DW'(nr); ncols = DW'(nc); sigma = SW'(sg);
    transpose = tp[0]; pad_mode = 2'(pm);
    @(negedge clk);
    start = 1'b0; nrows = DW'($urandom); ncols = DW'($urandom); sigma = SW'($urandom);
    transpose = 1'($urandom); pad_mode = 2'($urandom);
    for (int k = 0; k <= n + 2; k++) begin
      chk($sformatf("busy@%0d", k), int'(busy), int'(k <= n + 1));
      chk($sformatf("done@%0d", k), int'(done), int'(k == n + 2));
      chk($sformatf("err@%0d", k), int'(err), 0);
      if (done) done_cyc = k;
      if (k < n) begin
        row = k / w;
        p = pcol(k % w - TR, nc, pm);
        chk($sformatf("rd_en@%0d", k), int'(img_rd_en), int'(p >= 0));
        if (p >= 0) begin
          chk($sformatf("img_row@%0d", k), int'(img_row), row);
          chk($sformatf("img_col@%0d", k), int'(img_col), p);
        end
        if (row == 0) col_seq[k % w] = int'(img_col);
      end else begin
        chk($sformatf("rd_en@%0d", k), int'(img_rd_en), 0);
      end
      m = k - 2;
      if (m >= 0 && m < n && (m % w) >= 2 * TR) begin
        row = m / w;
        c = m % w - 2 * TR;
        er = (tp != 0) ? c : row;
        ec = (tp != 0) ? row : c;
        chk($sformatf("buf_we@%0d", k), int'(buf_we), 1);
        chk($sformatf("buf_row@%0d", k), int'(buf_row), er);
        chk($sformatf("buf_col@%0d", k), int'(buf_col), ec);
        chk($sformatf("buf_din r%0d c%0d", row, c), int'(buf_din), model_pix(row, c, nc, pm, sg));
        res[row][c] = int'(buf_din);
        wr_cnt++;
      end else begin
        chk($sformatf("buf_we@%0d", k), int'(buf_we), 0);
      end
      // A start while busy must be ignored; ncols=0 would raise err if taken.
      start = poke && (k == 5);
      if (start) ncols = '0;
      @(negedge clk);
    end
    start = 1'b0;
    chk("busy after fin", int'(busy), 0);
    chk("done after fin", int'(done), 0);
    chk("write count", wr_cnt, nr * nc);
  endtask

  task automatic reject(input int nr, input int nc, input int pm, input string nm);
    @(negedge clk);
    start = 1'b1; nrows = DW'(nr); ncols = DW'(nc); pad_mode = 2'(pm);
    sigma = '0; transpose = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk({nm, " err pulse"}, int'(err), 1);
    chk({nm, " busy"}, int'(busy), 0);
    chk({nm, " rd_en"}, int'(img_rd_en), 0);
    @(negedge clk);
    chk({nm, " err clear"}, int'(err), 0);
    chk({nm, " busy later"}, int'(busy), 0);
    chk({nm, " rd_en later"}, int'(img_rd_en), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int mir_seq [12];
    int clp_seq [12];
    int s;
    mir_seq = '{2, 1, 0, 1, 2, 3, 4, 5, 6, 7, 6, 5};
    clp_seq = '{0, 0, 0, 1, 2, 3, 4, 5, 6, 7, 7, 7};
    rst = 1'b1; start = 1'b0; nrows = '0; ncols = '0; sigma = '0;
    transpose = 1'b0; pad_mode = '0;
    fill(1, 0);
    repeat (2) @(negedge clk);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset err", int'(err), 0);
    chk("reset rd_en", int'(img_rd_en), 0);
    chk("reset buf_we", int'(buf_we), 0);
    chk("reset buf_din", int'(buf_din), 0);
    rst = 1'b0;

    // Coefficient sets: normalised, symmetric, and pinned by hand for sigma 0.
    for (int sg = 0; sg < 8; sg++) begin
      s = 0;
      for (int t = 0; t <= 2 * TR; t++) s += int'(gauss_coef(sg, t, TR));
      chk($sformatf("coef sum sg%0d", sg), s, 65536);
      chk($sformatf("coef sym sg%0d", sg), int'(gauss_coef(sg, 0, TR)),
          int'(gauss_coef(sg, 2 * TR, TR)));
    end
    chk("coef sg0 centre", int'(gauss_coef(0, 2, TR)), 27326);
    chk("coef sg0 d1", int'(gauss_coef(0, 1, TR)), 13662);
    chk("coef sg0 d2", int'(gauss_coef(0, 0, TR)), 5443);

    // Flat image, mirror: every output equals the input; done at 8*(8+4)+2.
    fill(0, 100);
    run_frame(8, 8, 3, 0, 0, 1'b0);
    chk("flat done cycle", done_cyc, 98);
    chk("flat r0c0", res[0][0], 100);
    chk("flat r7c7", res[7][7], 100);
    chk("mirror col seq", col_seq[0] * 1000 + col_seq[11] * 10 + col_seq[2],
        mir_seq[0] * 1000 + mir_seq[11] * 10 + mir_seq[2]);
    for (int j = 0; j < 12; j++) chk($sformatf("mirror col %0d", j), col_seq[j], mir_seq[j]);

    fill(1, 0);
    run_frame(3, 8, 1, 0, 1, 1'b0);
    for (int j = 0; j < 12; j++) chk($sformatf("clamp col %0d", j), col_seq[j], clp_seq[j]);
    run_frame(3, 8, 5, 0, 2, 1'b0);

    // Zero padding darkens the borders of a flat image.
    fill(0, 100);
    run_frame(2, 8, 0, 0, 2, 1'b0);
    chk("zero c0", res[0][0], 71);
    chk("zero c1", res[0][1], 92);
    chk("zero c7", res[1][7], 71);
    for (int c = 2; c <= 5; c++) chk($sformatf("zero mid c%0d", c), res[0][c], 100);

    fill(0, 255);
    run_frame(2, 5, 7, 0, 1, 1'b0);
    chk("saturate edge", res[1][4], 255);

    fill(1, 0);
    run_frame(4, 6, 4, 1, 0, 1'b0);
    chk("transpose writes", wr_cnt, 24);

    reject(4, 2, 0, "mirror narrow");
    reject(4, 8, 3, "pad illegal");
    reject(0, 8, 1, "zero rows");
    reject(4, 0, 1, "zero cols");
    run_frame(3, 2, 2, 0, 1, 1'b0);

    // Reset in the middle of a frame, then a clean frame with a start poked while busy.
    @(negedge clk);
    start = 1'b1; nrows = 8; ncols = 8; pad_mode = 0; sigma = 2; transpose = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("pre-reset busy", int'(busy), 1);
    chk("pre-reset buf_we", int'(buf_we), 1);
    #2 rst = 1'b1;
    #1;
    chk("mid reset busy", int'(busy), 0);
    chk("mid reset buf_we", int'(buf_we), 0);
    chk("mid reset rd_en", int'(img_rd_en), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("post reset we %0d", k), int'(buf_we), 0);
      chk($sformatf("post reset busy %0d", k), int'(busy), 0);
    end
    run_frame(8, 8, 2, 0, 0, 1'b1);

    for (int f = 0; f < 6; f++) begin
      int pm, nc;
      pm = int'($urandom_range(0, 2));
      nc = (pm == 0) ? int'($urandom_range(TR + 1, 12)) : int'($urandom_range(1, 12));
      fill(1, 0);
      run_frame(int'($urandom_range(1, 6)), nc, int'($urandom_range(0, 7)),
                int'($urandom_range(0, 1)), pm, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/conv_line_engine.md
Name: conv_line_engine

Overview:
- Parametrised successor of the row convolution controller: 1-D Gaussian convolution along image rows, kernel radius R (2R+1 taps).
- Streams pixels from the image SRAM and writes results to the buffer SRAM, optionally transposed so two passes give a separable 2-D blur.
- Adds start/done handshake, selectable border padding (mirror/clamp/zero), dimension checking, and gap-free row-to-row streaming.

Parameters:
PIX_W, 8, pixel width (bits)
DIM_W, 8, row/column index width
R, 5, kernel radius; window = 2R+1 taps
SIGMA_W, 3, sigma selector width

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
start  in  1  one-cycle request; accepted only when idle
nrows  in  DIM_W  image rows; latched at accepted start
ncols  in  DIM_W  image columns; latched at accepted start
sigma  in  SIGMA_W  kernel select; latched at accepted start
transpose  in  1  swap row/col on buffer writes; latched at accepted start
pad_mode  in  2  0=mirror, 1=clamp, 2=zero, 3=illegal; latched at accepted start
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at completion
err  out  1  one-cycle pulse when a start is rejected
img_rd_en  out  1  image SRAM read strobe
img_row  out  DIM_W  image read row
img_col  out  DIM_W  image read column
img_dout  in  PIX_W  image data, valid the cycle after the read
buf_we  out  1  buffer SRAM write enable
buf_row  out  DIM_W  buffer write row
buf_col  out  DIM_W  buffer write column
buf_din  out  PIX_W  convolved pixel

Behaviour:
- Reset (async, immediate): busy, done, err, img_rd_en, buf_we = 0; all addresses/data 0; FSM -> IDLE; window and valid counters cleared. Reset mid-operation abandons the frame; no further writes.
- States: IDLE -> RUN -> DRAIN -> FIN -> IDLE.
- IDLE: on start, validate the dimensions.
  - Reject if nrows==0, ncols==0, pad_mode==3, or (mirror and ncols<=R).
  - Reject: err=1 for one cycle, stay IDLE, no reads.
  - Otherwise latch all inputs and go to RUN.
- start while busy: ignored, no err.
- RUN: one virtual index per cycle, v = -R .. ncols-1+R per row, rows 0..nrows-1 back to back with no bubble. Each row is ncols+2R cycles; N = nrows*(ncols+2R) reads total.
- Physical column for v<0 or v>=ncols:
  - mirror: -v, or 2(ncols-1)-v (edge pixel not repeated);
  - clamp: 0, or ncols-1;
  - zero: img_rd_en=0 and a zero is injected in place of data; the inject flag is delayed one cycle to align with the data.
- In-range v: img_rd_en=1, img_col=v, img_row=current row.
- Pipeline:
  - read in cycle k; img_dout captured into the shift window at the end of cycle k+1;
  - window + kernel result valid in cycle k+2, where buf_we is driven.
- Per-row valid counter: a write occurs only once 2R+1 samples of the current row are in the window. The first 2R samples of each row produce no write, so a new row's preload never mixes with the previous row.
- Write address: output column c is written when the window holds v=c-R..c+R.
  - transpose=0: buf_row=row, buf_col=c.
  - transpose=1: buf_row=c, buf_col=row.
- DRAIN: 2 cycles after the last read, to flush the pipeline. Last write is in cycle N+1 (cycle 0 = first read).
- FIN: done=1 and busy falls in cycle N+2; return to IDLE. Exactly nrows*ncols writes per frame.
- Arithmetic:
  - coefficients unsigned Q0.16, each sigma's set sums to 65536;
  - accumulator PIX_W+16+clog2(2R+1) bits;
  - round half-up on bit 15, then saturate to 2^PIX_W-1.
- The img_dout path is taken as-is; the SRAM has fixed 1-cycle read latency and no stall.

Decomposition:
- Extend img_sram_pkg: pad_mode_e enum, and function gauss_coef(sigma, tap, R) returning Q0.16.
- Sub-module gauss_kernel_dotprod_p #(R, PIX_W, SIGMA_W): combinational window dot product with rounding and saturation.
- The window shift register stays inline.

Test Plan:
1. R=5, 8x8 image all 100, mirror, sigma=3 -> 64 writes, all buf_din=100; done pulse in cycle 8*18+2=146; busy high for exactly the cycles in between.
2. R=2, ncols=8, mirror -> img_col sequence per row 2,1,0,1,2,...,7,6,5. Clamp -> 0,0,0,1,...,7,7,7. Zero -> img_rd_en low for the 2+2 pad cycles per row.
3. R=2, zero pad, constant 100 -> columns 0 and 7 < 100, columns 2..5 = 100; mirror on the same image -> all 100.
4. transpose=1, nrows=4, ncols=6 -> 24 writes; pixel (r,c) lands at buf_row=c, buf_col=r; rows written in order without gaps.
5. R=5, ncols=5, mirror -> err pulse, busy stays 0, no reads. Same with clamp -> accepted, completes normally. pad_mode=3 -> err.
6. Assert rst at cycle 20 of an 8x8 run -> buf_we and busy 0 immediately. Next start runs a full frame from row 0 with correct output; start pulsed during busy -> ignored.
